seg_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment scan controller with a memory-mapped write port.
//  - Drives DIGITS common-anode digits from a 4*DIGITS-bit hex value.
//  - Adds three things the single-register display driver lacks: a per-digit decimal-point

---
 rtl/seg_scan_ctrl_if.sv | 13 +
 rtl/seg_scan_ctrl.sv | 177 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Peripheral write-bus bundle for seg_scan_ctrl.
//   wr_en   : single-cycle write strobe
//   wr_addr : 12-bit byte address
//   wr_data : 32-bit write data
// The CPU side uses the master modport; the display controller uses slave.
interface seg_scan_ctrl_if;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed common-anode 7-segment scan controller.
//   Scans DIGITS digits from index DIGITS-1 down to 0, one slot of SCAN_CYCLES
//   clocks each. Three bus registers (DATA, DP, MASK) each have a pending copy
//   written by the bus and a live copy used for display; pending copies move to
//   live only at the end of the digit-0 slot, so a frame never shows a mix of
//   old and new values.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus (slave)           wr_en / wr_addr / wr_data write port
//   led_en[DIGITS-1:0]    digit anode enables, active low
//   led_ca..led_cg        segments a..g, active low
//   led_dp                decimal point, active low
//   frame_done            one-cycle pulse after the digit-0 slot ends
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan_ctrl #(
    parameter int          DIGITS      = 8,
    parameter int          SCAN_CYCLES = 10000,
    parameter logic [11:0] BASE_ADDR   = 12'h000
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_ctrl_if.slave    bus,
    output logic [DIGITS-1:0] led_en,
    output logic              led_ca,
    output logic              led_cb,
    output logic              led_cc,
    output logic              led_cd,
    output logic              led_ce,
    output logic              led_cf,
    output logic              led_cg,
    output logic              led_dp,
    output logic              frame_done
);
    localparam int          DW       = 4 * DIGITS;
    localparam int          IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          CNT_W    = $clog2(SCAN_CYCLES);
    localparam logic [11:0] DP_ADDR  = BASE_ADDR + 12'd4;
    localparam logic [11:0] MSK_ADDR = BASE_ADDR + 12'd8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Active-low hex font, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // True when digit i and every digit above it are zero; digit 0 never blanks.
    function automatic logic lead_zero(input logic [DW-1:0] v, input logic [IDX_W-1:0] i);
        logic z;
        z = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= int'(i) && v[4*k +: 4] != 4'h0) z = 1'b0;
        end
        return z && (i != '0);
    endfunction
`endif

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DW-1:0]     data_pend_q, data_pend_d, data_live_q, data_live_d;
    logic [DIGITS-1:0] dp_pend_q, dp_pend_d, dp_live_q, dp_live_d;
    logic [DIGITS-1:0] mask_pend_q, mask_pend_d, mask_live_q, mask_live_d;
    logic              pend_q, pend_d;
    logic [DIGITS-1:0] en_q, en_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              frame_q;
    logic              wrap, commit, hit_data, hit_dp, hit_mask;
    logic [3:0]        nib;

    always_comb begin
        wrap     = (cnt_q == CNT_LAST);
        // The digit-0 slot ends on the wrap edge taken while index is 0.
        commit   = wrap && (idx_q == '0);
        cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        if (wrap) idx_d = (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);

        hit_data = bus.wr_en && (bus.wr_addr == BASE_ADDR);
        hit_dp   = bus.wr_en && (bus.wr_addr == DP_ADDR);
        hit_mask = bus.wr_en && (bus.wr_addr == MSK_ADDR);

        data_pend_d = hit_data ? bus.wr_data[DW-1:0]     : data_pend_q;
        dp_pend_d   = hit_dp   ? bus.wr_data[DIGITS-1:0] : dp_pend_q;
        mask_pend_d = hit_mask ? bus.wr_data[DIGITS-1:0] : mask_pend_q;

        // Live copies take the pending values held before this edge's write,
        // so a colliding write waits for the next frame.
        data_live_d = data_live_q;
        dp_live_d   = dp_live_q;
        mask_live_d = mask_live_q;
        if (commit && pend_q) begin
            data_live_d = data_pend_q;
            dp_live_d   = dp_pend_q;
            mask_live_d = mask_pend_q;
        end

        pend_d = pend_q;
        if (commit) pend_d = 1'b0;
        if (hit_data || hit_dp || hit_mask) pend_d = 1'b1;

        // Pattern for the slot that starts on this wrap edge.
        nib   = data_live_d[{idx_d, 2'b00} +: 4];
        seg_d = hex_font(nib);
`ifdef LEADING_ZERO_BLANK_EN
        if (lead_zero(data_live_d, idx_d)) seg_d = 7'h7F;
`endif
        dp_d  = ~dp_live_d[idx_d];
        en_d  = '1;
        if (mask_live_d[idx_d]) en_d[idx_d] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= IDX_LAST;
            data_pend_q <= '0;
            data_live_q <= '0;
            dp_pend_q   <= '0;
            dp_live_q   <= '0;
            mask_pend_q <= '1;
            mask_live_q <= '1;
            pend_q      <= 1'b0;
            en_q        <= '1;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            data_pend_q <= data_pend_d;
            data_live_q <= data_live_d;
            dp_pend_q   <= dp_pend_d;
            dp_live_q   <= dp_live_d;
            mask_pend_q <= mask_pend_d;
            mask_live_q <= mask_live_d;
            pend_q      <= pend_d;
            frame_q     <= commit;
            if (wrap) begin
                en_q  <= en_d;
                seg_q <= seg_d;
                dp_q  <= dp_d;
            end
        end
    end

    assign led_en     = en_q;
    assign led_ca     = seg_q[0];
    assign led_cb     = seg_q[1];
    assign led_cc     = seg_q[2];
    assign led_cd     = seg_q[3];
    assign led_ce     = seg_q[4];
    assign led_cf     = seg_q[5];
    assign led_cg     = seg_q[6];
    assign led_dp     = dp_q;
    assign frame_done = frame_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DIGITS=8, SCAN_CYCLES=4, BASE_ADDR=12'h100.
module tb_seg_scan_ctrl;
    localparam int          D    = 8;
    localparam int          SC   = 4;
    localparam logic [11:0] BASE = 12'h100;
    localparam logic [6:0]  FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic clk, rst_n;
    logic [D-1:0] led_en;
    logic led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp, frame_done;
    seg_scan_ctrl_if bus_if ();

    seg_scan_ctrl #(.DIGITS(D), .SCAN_CYCLES(SC), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if),
        .led_en(led_en), .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
        .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state: edges since reset release, bus registers, expected outputs.
    int          e;
    logic [31:0] m_data_p, m_data_l;
    logic [7:0]  m_dp_p, m_dp_l, m_mask_p, m_mask_l;
    logic        m_pend;
    logic [7:0]  x_en;
    logic [6:0]  x_seg;
    logic        x_dp, x_frame;

    function automatic logic [6:0] seg_obs();
        return {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic model_reset();
        e = 0;
        m_data_p = '0; m_data_l = '0;
        m_dp_p = '0; m_dp_l = '0;
        m_mask_p = '1; m_mask_l = '1;
        m_pend = 1'b0;
        x_en = 8'hFF; x_seg = 7'h7F; x_dp = 1'b1; x_frame = 1'b0;
    endtask

    // Slot n (n-th wrap after release) shows digit (D-1-n) mod D; the frame
    // boundary is every D-th wrap, which is when pending values go live.
    task automatic model_edge(input logic en, input logic [11:0] addr, input logic [31:0] data);
        int n, ix;
        e++;
        x_frame = 1'b0;
        if (e % SC == 0) begin
            n = e / SC;
            if (n % D == 0) begin
                x_frame = 1'b1;
                if (m_pend) begin
                    m_data_l = m_data_p; m_dp_l = m_dp_p; m_mask_l = m_mask_p;
                end
                m_pend = 1'b0;
            end
            ix    = D - 1 - (n % D);
            x_en  = m_mask_l[ix] ? ~(8'h01 << ix) : 8'hFF;
            x_seg = FONT[(m_data_l >> (4*ix)) & 32'hF];
`ifdef LEADING_ZERO_BLANK_EN
            if (ix != 0 && (m_data_l >> (4*ix)) == 0) x_seg = 7'h7F;
`endif
            x_dp  = ~m_dp_l[ix];
        end
        if (en) begin
            if (addr == BASE)             begin m_data_p = data;       m_pend = 1'b1; end
            else if (addr == BASE + 12'd4) begin m_dp_p   = data[7:0];  m_pend = 1'b1; end
            else if (addr == BASE + 12'd8) begin m_mask_p = data[7:0];  m_pend = 1'b1; end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".led_en"}, 32'(led_en), 32'(x_en));
        chk({tag, ".seg"}, 32'(seg_obs()), 32'(x_seg));
        chk({tag, ".led_dp"}, 32'(led_dp), 32'(x_dp));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(x_frame));
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic tick(input string tag, input logic en, input logic [11:0] addr, input logic [31:0] data);
        bus_if.wr_en = en; bus_if.wr_addr = addr; bus_if.wr_data = data;
        @(posedge clk);
        model_edge(en, addr, data);
        #1;
        check_all(tag);
        @(negedge clk);
        bus_if.wr_en = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag, 1'b0, 12'h0, 32'h0);
    endtask

    task automatic write(input string tag, input logic [11:0] addr, input logic [31:0] data);
        tick(tag, 1'b1, addr, data);
    endtask

    initial begin
        int t1, t2, lim;
        logic [11:0] ra;
        clk = 1'b0; rst_n = 1'b0;
        bus_if.wr_en = 1'b0; bus_if.wr_addr = '0; bus_if.wr_data = '0;
        model_reset();

        // Reset values while held.
        repeat (5) @(negedge clk);
        chk("rst.led_en", 32'(led_en), 32'hFF);
        chk("rst.seg", 32'(seg_obs()), 32'h7F);
        chk("rst.led_dp", 32'(led_dp), 32'h1);
        chk("rst.frame_done", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        // Outputs hold for SC-1 cycles, then first slot shows digit 6.
        idle("post_rst", SC - 1);
        idle("first_slot", 1);
        chk("first.led_en", 32'(led_en), 32'hBF);

        // Scan pattern 01234567.
        write("wr_data", BASE, 32'h01234567);
        idle("scan", 70);

        // frame_done period.
        t1 = -1; t2 = -1; lim = 0;
        while (t2 < 0 && lim < 80) begin
            idle("period", 1);
            lim++;
            if (frame_done) begin
                if (t1 < 0) t1 = e; else t2 = e;
            end
        end
        chk("frame_period", 32'(t2 - t1), 32'd32);

        // Tear-free update written mid-frame.
        idle("tear_pre", 9);
        write("wr_ff", BASE, 32'hFFFFFFFF);
        idle("tear", 70);

        // Mask / DP.
        write("wr_mask", BASE + 12'd8, 32'h0000000F);
        write("wr_dp", BASE + 12'd4, 32'h00000001);
        idle("mask_dp", 70);

        // Collision on the commit edge, plus an unmapped address.
        write("wr_data2", BASE, 32'h89ABCDEF);
        while ((e + 1) % (SC * D) != 0) idle("align", 1);
        write("collide", BASE, 32'h13572468);
        write("unmapped", BASE + 12'd12, 32'hDEADBEEF);
        idle("collide_run", 70);

        // Leading-zero case and all-dark mask.
        write("wr_mask_ff", BASE + 12'd8, 32'hFF);
        write("wr_lz", BASE, 32'h00000050);
        idle("lz", 70);
        write("wr_mask0", BASE + 12'd8, 32'h0);
        idle("dark", 70);

        // Randomised traffic.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 4))
                    0: ra = BASE;
                    1: ra = BASE + 12'd4;
                    2: ra = BASE + 12'd8;
                    3: ra = BASE + 12'd12;
                    default: ra = 12'($urandom);
                endcase
                write("rand", ra, $urandom >> $urandom_range(0, 31));
            end else begin
                idle("rand", 1);
            end
        end

        // Asynchronous reset mid-slot discards pending writes.
        write("wr_lost", BASE, 32'hABCDEF12);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.led_en", 32'(led_en), 32'hFF);
        chk("midrst.seg", 32'(seg_obs()), 32'h7F);
        chk("midrst.led_dp", 32'(led_dp), 32'h1);
        chk("midrst.frame_done", 32'(frame_done), 32'h0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle("after_rst", 80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
